// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a multi-digit 7-segment display.
// Scans one digit per slot and decodes hex nibbles to {a,b,c,d,e,f,g,dp}.
// New data goes into a pending buffer and moves to the displayed buffer only at a
// frame boundary, so a frame never mixes old and new digits.
// Also handles per-digit dp and blanking, leading-zero suppression, and a dead
// time at the start of each slot that prevents ghosting between digits.
module seven_seg_scanner #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  load,
    input  logic                  lz_suppress,
    input  logic                  enable,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [7:0]        SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_OFF    = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}}
                                                                   : {DIGITS{1'b0}};

    // Hex nibble to segments a..g, with a in the MSB. A 1 means the segment is lit.
    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        logic [6:0] segs;
        case (nib)
            4'h0:    segs = 7'b1111110;
            4'h1:    segs = 7'b0110000;
            4'h2:    segs = 7'b1101101;
            4'h3:    segs = 7'b1111001;
            4'h4:    segs = 7'b0110011;
            4'h5:    segs = 7'b1011011;
            4'h6:    segs = 7'b1011111;
            4'h7:    segs = 7'b1110000;
            4'h8:    segs = 7'b1111111;
            4'h9:    segs = 7'b1111011;
            4'hA:    segs = 7'b1110111;
            4'hB:    segs = 7'b0011111;
            4'hC:    segs = 7'b1001110;
            4'hD:    segs = 7'b0111101;
            4'hE:    segs = 7'b1001111;
            default: segs = 7'b1000111;
        endcase
        return segs;
    endfunction

    // Scan state.
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                tick;
    logic                frame_tick;

    // Pending buffer, written by load.
    logic                pend_flag_q, pend_flag_d;
    logic [4*DIGITS-1:0] pend_value_q, pend_value_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;

    // Displayed buffer, updated only at a frame boundary.
    logic [4*DIGITS-1:0] act_value_q, act_value_d;
    logic [DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [DIGITS-1:0]   act_blank_q, act_blank_d;

    // Fields of the digit in the current slot.
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic                cur_lz;
    logic [DIGITS-1:0]   an_onehot;
    logic [DIGITS-1:0]   lz_mask;

    // Output registers.
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_start_q, frame_start_d;

    // Prescaler and digit index. The index advances at the end of every slot.
    always_comb begin
        tick       = (cnt_q == CNT_LAST);
        frame_tick = tick && (idx_q == IDX_LAST);
        cnt_d      = cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        if (tick) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Double buffer. The displayed copy takes the pending copy as it was before this
    // cycle, so a load on the boundary cycle waits for the next frame.
    always_comb begin
        pend_flag_d  = pend_flag_q;
        pend_value_d = pend_value_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        act_value_d  = act_value_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        if (frame_tick && pend_flag_q) begin
            act_value_d = pend_value_q;
            act_dp_d    = pend_dp_q;
            act_blank_d = pend_blank_q;
            pend_flag_d = 1'b0;
        end
        if (load) begin
            pend_value_d = value;
            pend_dp_d    = dp_in;
            pend_blank_d = blank_in;
            pend_flag_d  = 1'b1;
        end
    end

    // A digit counts as a leading zero when it and every digit above it are zero.
    // Digit 0 is never a leading zero.
    always_comb begin : lz_scan
        logic run_zero;
        run_zero = 1'b1;
        lz_mask  = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run_zero   = run_zero && (act_value_q[4*i +: 4] == 4'h0);
            lz_mask[i] = run_zero;
        end
    end

    // Select the nibble, dp, blank and leading-zero flag of the digit in the current slot.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        cur_lz    = 1'b0;
        an_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib      = act_value_q[4*i +: 4];
                cur_dp       = act_dp_q[i];
                cur_blank    = act_blank_q[i];
                cur_lz       = lz_suppress && lz_mask[i];
                an_onehot[i] = 1'b1;
            end
        end
    end

    // Next output values. A dark slot, the dead time or enable=0 forces all outputs
    // inactive. A suppressed zero that has dp set shows dp only.
    always_comb begin : out_logic
        logic [7:0]        seg_raw;
        logic [DIGITS-1:0] an_raw;
        logic              dark;
        logic              dead;
        seg_raw = 8'h00;
        an_raw  = '0;
        dark    = cur_blank || (cur_lz && !cur_dp);
        dead    = (cnt_q < CNT_BLANK);
        if (enable && !dead && !dark) begin
            an_raw = an_onehot;
            if (cur_lz) begin
                seg_raw = {7'b0000000, cur_dp};
            end else begin
                seg_raw = {decode_hex(cur_nib), cur_dp};
            end
        end
        seg_d         = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
        an_d          = (AN_ACTIVE_LOW != 0) ? ~an_raw : an_raw;
        frame_start_d = (cnt_q == '0) && (idx_q == '0);
    end

    // All state registers. After reset the display shows every digit blanked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            pend_flag_q   <= 1'b0;
            pend_value_q  <= '0;
            pend_dp_q     <= '0;
            pend_blank_q  <= '0;
            act_value_q   <= '0;
            act_dp_q      <= '0;
            act_blank_q   <= {DIGITS{1'b1}};
            seg_q         <= SEG_OFF;
            an_q          <= AN_OFF;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            pend_flag_q   <= pend_flag_d;
            pend_value_q  <= pend_value_d;
            pend_dp_q     <= pend_dp_d;
            pend_blank_q  <= pend_blank_d;
            act_value_q   <= act_value_d;
            act_dp_q      <= act_dp_d;
            act_blank_q   <= act_blank_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed checks of the scanner with 4 digits, 4 cycles per
// slot, 1 dead-time cycle and active-low outputs (16 clocks per frame).
module tb_seven_seg_scanner;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic        lz_suppress;
    logic        enable;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_start;

    int total;
    int bad;

    // Data applied by the load pulses inside check_frame.
    logic [15:0] nxt1_value, nxt2_value;
    logic [3:0]  nxt1_dp, nxt2_dp, nxt1_blank, nxt2_blank;

    seven_seg_scanner #(
        .DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .blank_in(blank_in),
        .load(load), .lz_suppress(lz_suppress), .enable(enable),
        .seg(seg), .an(an), .frame_start(frame_start)
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison: counts it, and reports and counts a mismatch.
    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks one full frame starting at the negedge where frame_start should be 1.
    // lit marks the digits expected to light, and segs gives their seg values.
    // A load pulse is driven at position lk1 (nxt1 data) and at lk2 (nxt2 data).
    // On return the bench sits at position 0 of the next frame.
    task automatic check_frame(input string tag, input logic [3:0] lit,
                               input logic [3:0][7:0] segs, input int lk1, input int lk2);
        for (int k = 0; k < 16; k++) begin
            int          s;
            logic [3:0]  exp_an;
            logic [7:0]  exp_seg;
            s    = k / 4;
            load = 1'b0;
            if (k == lk1) begin
                value = nxt1_value; dp_in = nxt1_dp; blank_in = nxt1_blank; load = 1'b1;
            end
            if (k == lk2) begin
                value = nxt2_value; dp_in = nxt2_dp; blank_in = nxt2_blank; load = 1'b1;
            end
            if ((k % 4) == 0 || !lit[s]) begin
                exp_an  = 4'hF;
                exp_seg = 8'hFF;
            end else begin
                exp_an  = 4'hF & ~(4'b0001 << s);
                exp_seg = segs[s];
            end
            check_output($sformatf("%s k=%0d an", tag, k), {4'h0, an}, {4'h0, exp_an});
            check_output($sformatf("%s k=%0d seg", tag, k), seg, exp_seg);
            check_output($sformatf("%s k=%0d fs", tag, k), {7'h0, frame_start},
                         {7'h0, (k == 0)});
            @(negedge clk);
        end
    endtask

    // Sets the data for the next pair of load pulses.
    task automatic apply_stimulus(input logic [15:0] v1, input logic [3:0] d1, input logic [3:0] b1,
                                  input logic [15:0] v2, input logic [3:0] d2, input logic [3:0] b2);
        nxt1_value = v1; nxt1_dp = d1; nxt1_blank = b1;
        nxt2_value = v2; nxt2_dp = d2; nxt2_blank = b2;
    endtask

    // Directed sequence, run as a single linear flow.
    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        value = 16'h0; dp_in = 4'h0; blank_in = 4'h0; load = 1'b0;
        lz_suppress = 1'b0; enable = 1'b1;
        apply_stimulus(16'h0, 4'h0, 4'h0, 16'h0, 4'h0, 4'h0);

        repeat (3) @(negedge clk);
        check_output("reset an", {4'h0, an}, 8'h0F);
        check_output("reset seg", seg, 8'hFF);
        check_output("reset fs", {7'h0, frame_start}, 8'h00);
        reset = 1'b0;
        @(negedge clk);

        // Dark after reset. A mid-frame load must not show until the next frame.
        apply_stimulus(16'h1234, 4'h0, 4'h0, 16'h0, 4'h0, 4'h0);
        check_frame("dark0", 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 5, -1);
        apply_stimulus(16'h0050, 4'h0, 4'h0, 16'h0, 4'h0, 4'h0);
        check_frame("v1234", 4'b1111, {8'h9F, 8'h25, 8'h0D, 8'h99}, 3, -1);

        // Leading-zero suppression, which takes effect immediately.
        lz_suppress = 1'b1;
        apply_stimulus(16'h0000, 4'h0, 4'h0, 16'h0, 4'h0, 4'h0);
        check_frame("lz0050", 4'b0011, {8'hFF, 8'hFF, 8'h49, 8'h03}, 3, -1);
        apply_stimulus(16'h0050, 4'b0100, 4'h0, 16'h0, 4'h0, 4'h0);
        check_frame("lz0000", 4'b0001, {8'hFF, 8'hFF, 8'hFF, 8'h03}, 3, -1);

        // Two loads in one frame: only the second one is displayed.
        apply_stimulus(16'h1111, 4'h0, 4'h0, 16'h2222, 4'h0, 4'h0);
        check_frame("lzdp", 4'b0111, {8'hFF, 8'hFE, 8'h49, 8'h03}, 2, 8);

        // Load mid-frame, then load again on the boundary cycle.
        apply_stimulus(16'h4444, 4'h0, 4'h0, 16'h00E0, 4'b0001, 4'b1000);
        check_frame("v2222", 4'b1111, {8'h25, 8'h25, 8'h25, 8'h25}, 8, 14);
        lz_suppress = 1'b0;
        check_frame("v4444", 4'b1111, {8'h99, 8'h99, 8'h99, 8'h99}, -1, -1);
        check_frame("v00E0", 4'b0111, {8'hFF, 8'h03, 8'h61, 8'h02}, -1, -1);

        // enable=0 blanks the display while frame_start keeps pulsing.
        enable = 1'b0;
        check_frame("dis0", 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, -1, -1);
        check_frame("dis1", 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, -1, -1);
        enable = 1'b1;
        check_frame("reen", 4'b0111, {8'hFF, 8'h03, 8'h61, 8'h02}, -1, -1);

        // Asynchronous reset in the middle of the digit 2 slot.
        repeat (9) @(negedge clk);
        check_output("pre-rst an", {4'h0, an}, 8'h0B);
        check_output("pre-rst seg", seg, 8'h03);
        reset = 1'b1;
        #1;
        check_output("async an", {4'h0, an}, 8'h0F);
        check_output("async seg", seg, 8'hFF);
        @(negedge clk);
        check_output("held an", {4'h0, an}, 8'h0F);
        reset = 1'b0;
        @(negedge clk);
        check_frame("post0", 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, -1, -1);
        check_frame("post1", 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, -1, -1);

        $display("[TB] directed sequence complete");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
